// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: a fetch bus and a data bus share one downstream port.
// One transaction is outstanding at a time; a starvation counter bounds how long fetch can lose.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,
    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,
    output logic        mreq_valid,
    output logic        mreq_is_write,
    output logic [63:0] mreq_addr,
    output logic [2:0]  mreq_size,
    output logic [7:0]  mreq_strobe,
    output logic [63:0] mreq_data,
    input  logic        mresp_ready,
    input  logic        mresp_valid,
    input  logic [63:0] mresp_data
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

    state_t        state_reg, state_next;
    owner_t        owner_reg;
    logic [SW-1:0] starve_reg;
    logic [63:0]   rdata_reg;
    logic          isel_hi_reg;
    logic          grant_i, grant_d, take_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        grant_i       = 1'b0;
        grant_d       = 1'b0;
        take_data     = 1'b0;
        mreq_valid    = 1'b0;
        iresp_addr_ok = 1'b0;
        dresp_addr_ok = 1'b0;
        iresp_data_ok = 1'b0;
        dresp_data_ok = 1'b0;
        case (state_reg)
            IDLE: begin
                // Data bus has priority until fetch has lost STARVE_LIMIT grants in a row.
                if (dreq_valid && !(ireq_valid && starve_reg == LIMIT)) begin
                    grant_d = 1'b1;
                end else if (ireq_valid) begin
                    grant_i = 1'b1;
                end
                if (grant_i || grant_d) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                mreq_valid = 1'b1;
                if (mresp_ready) begin
                    iresp_addr_ok = (owner_reg == OWN_I);
                    dresp_addr_ok = (owner_reg == OWN_D);
                    if (mresp_valid) begin
                        take_data  = 1'b1;
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mresp_valid) begin
                    take_data  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                iresp_data_ok = (owner_reg == OWN_I);
                dresp_data_ok = (owner_reg == OWN_D);
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_reg     <= OWN_NONE;
            starve_reg    <= '0;
            rdata_reg     <= '0;
            isel_hi_reg   <= 1'b0;
            mreq_is_write <= 1'b0;
            mreq_addr     <= '0;
            mreq_size     <= '0;
            mreq_strobe   <= '0;
            mreq_data     <= '0;
        end else begin
            if (grant_d) begin
                owner_reg     <= OWN_D;
                mreq_is_write <= |dreq_strobe;
                mreq_addr     <= dreq_addr;
                mreq_size     <= dreq_size;
                mreq_strobe   <= dreq_strobe;
                mreq_data     <= dreq_data;
                if (!ireq_valid) begin
                    starve_reg <= '0;
                end else if (starve_reg != LIMIT) begin
                    starve_reg <= starve_reg + SW'(1);
                end
            end else if (grant_i) begin
                owner_reg     <= OWN_I;
                mreq_is_write <= 1'b0;
                mreq_addr     <= ireq_addr;
                mreq_size     <= 3'b010;
                mreq_strobe   <= '0;
                mreq_data     <= '0;
                isel_hi_reg   <= ireq_addr[2];
                starve_reg    <= '0;
            end
            if (take_data) begin
                rdata_reg <= mresp_data;
            end
            if (state_reg == RESP) begin
                owner_reg <= OWN_NONE;
            end
        end
    end

    assign iresp_data = isel_hi_reg ? rdata_reg[63:32] : rdata_reg[31:0];
    assign dresp_data = rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard of expected responses popped on each data_ok.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_addr_ok, iresp_data_ok;
    logic [31:0] iresp_data;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dreq_data;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [63:0] dresp_data;
    logic        mreq_valid, mreq_is_write;
    logic [63:0] mreq_addr;
    logic [2:0]  mreq_size;
    logic [7:0]  mreq_strobe;
    logic [63:0] mreq_data;
    logic        mresp_ready, mresp_valid;
    logic [63:0] mresp_data;

    typedef struct {
        logic        is_d;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .mreq_valid(mreq_valid), .mreq_is_write(mreq_is_write), .mreq_addr(mreq_addr),
        .mreq_size(mreq_size), .mreq_strobe(mreq_strobe), .mreq_data(mreq_data),
        .mresp_ready(mresp_ready), .mresp_valid(mresp_valid), .mresp_data(mresp_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance until either data_ok fires (bounded), then pop and compare against the scoreboard.
    task automatic wait_resp(input string tag, input int max_cyc, output int cyc);
        exp_t        e;
        logic        got;
        logic [63:0] obs;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < max_cyc) begin
            tick();
            cyc++;
            got = iresp_data_ok | dresp_data_ok;
        end
        check({tag, "_seen"}, {63'd0, got}, 64'd1);
        if (got) begin
            if (sb.size() == 0) begin
                check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
            end else begin
                e = sb.pop_front();
                check({tag, "_owner"}, {62'd0, dresp_data_ok, iresp_data_ok},
                      e.is_d ? 64'd2 : 64'd1);
                obs = e.is_d ? dresp_data : {32'd0, iresp_data};
                check({tag, "_data"}, obs, e.data);
            end
        end
        $display("txn %s: done after %0d cycles", tag, cyc);
    endtask

    initial begin
        reset = 1'b0;
        ireq_valid = 1'b0; ireq_addr = '0;
        dreq_valid = 1'b0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
        mresp_ready = 1'b0; mresp_valid = 1'b0; mresp_data = '0;
        tick();
        tick();
        check("rst_mreq_valid", {63'd0, mreq_valid}, 64'd0);
        check("rst_oks", {60'd0, iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok}, 64'd0);
        check("rst_mreq_addr", mreq_addr, 64'd0);
        check("rst_dresp_data", dresp_data, 64'd0);
        reset = 1'b1;

        // Fetch, upper word selected, minimum latency
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0004;
        mresp_ready = 1'b1; mresp_valid = 1'b1; mresp_data = 64'h1111_2222_3333_4444;
        sb.push_back('{1'b0, 64'h1111_2222});
        tick();
        check("i_mreq_valid", {63'd0, mreq_valid}, 64'd1);
        check("i_mreq_addr", mreq_addr, 64'h8000_0004);
        check("i_fields", {mreq_is_write, mreq_size, mreq_strobe, mreq_data[51:0]}, {1'b0, 3'b010, 60'd0});
        check("i_addr_ok", {62'd0, iresp_addr_ok, dresp_addr_ok}, 64'd2);
        wait_resp("fetch_min", 4, n);
        check("fetch_latency", 64'(n), 64'd1);
        ireq_valid = 1'b0;
        tick();
        check("i_pulse", {62'd0, iresp_data_ok, mreq_valid}, 64'd0);

        // Both valid: store wins, fetch follows
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0000;
        dreq_valid = 1'b1; dreq_addr = 64'h8000_1000; dreq_size = 3'b011;
        dreq_strobe = 8'hFF; dreq_data = 64'hDEAD_BEEF_0123_4567;
        mresp_data = 64'h0102_0304_0506_0708;
        sb.push_back('{1'b1, 64'h0102_0304_0506_0708});
        tick();
        check("d_is_write", {63'd0, mreq_is_write}, 64'd1);
        check("d_mreq_addr", mreq_addr, 64'h8000_1000);
        check("d_mreq_data", mreq_data, 64'hDEAD_BEEF_0123_4567);
        check("d_strobe_size", {53'd0, mreq_strobe, mreq_size}, {53'd0, 8'hFF, 3'b011});
        check("d_addr_ok", {62'd0, iresp_addr_ok, dresp_addr_ok}, 64'd1);
        wait_resp("both_d", 4, n);
        dreq_valid = 1'b0;
        mresp_data = 64'hAAAA_BBBB_CCCC_DDDD;
        sb.push_back('{1'b0, 64'hCCCC_DDDD});
        wait_resp("both_i", 6, n);
        check("both_i_cycles", 64'(n), 64'd3);
        ireq_valid = 1'b0;
        tick();

        // Starvation: four data grants, then fetch, then data again
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0000;
        dreq_valid = 1'b1; dreq_strobe = 8'h00; dreq_addr = 64'h8000_0100;
        for (int g = 0; g < 5; g++) begin
            mresp_data = {32'hA000_0000 + 32'(g), 32'hB000_0000 + 32'(g)};
            if (g < 4) sb.push_back('{1'b1, mresp_data});
            else       sb.push_back('{1'b0, {32'd0, 32'hB000_0000 + 32'(g)}});
            wait_resp("starve", 6, n);
        end
        ireq_valid = 1'b0;
        mresp_data = 64'h5A5A_5A5A_A5A5_A5A5;
        sb.push_back('{1'b1, 64'h5A5A_5A5A_A5A5_A5A5});
        wait_resp("after_starve", 6, n);
        dreq_valid = 1'b0;
        tick();

        // Slow downstream: ready late, data later still
        mresp_ready = 1'b0; mresp_valid = 1'b0;
        dreq_valid = 1'b1; dreq_addr = 64'h8000_2008; dreq_size = 3'b011;
        dreq_strobe = 8'h00; dreq_data = 64'h1234;
        tick();
        check("slow_req_valid", {62'd0, mreq_valid, dresp_addr_ok}, 64'd2);
        dreq_addr = 64'hFFFF; dreq_strobe = 8'hFF;
        tick();
        tick();
        check("slow_addr_hold", mreq_addr, 64'h8000_2008);
        check("slow_write_hold", {63'd0, mreq_is_write}, 64'd0);
        mresp_ready = 1'b1;
        #1;
        check("slow_addr_ok", {63'd0, dresp_addr_ok}, 64'd1);
        tick();
        mresp_ready = 1'b0;
        #1;
        check("slow_wait", {62'd0, dresp_addr_ok, mreq_valid}, 64'd0);
        check("slow_wait_addr", mreq_addr, 64'h8000_2008);
        tick();
        mresp_valid = 1'b1; mresp_data = 64'hCAFE_F00D_0000_0001;
        sb.push_back('{1'b1, 64'hCAFE_F00D_0000_0001});
        wait_resp("slow", 3, n);
        check("slow_latency", 64'(n), 64'd1);
        dreq_valid = 1'b0; mresp_valid = 1'b0; dreq_strobe = 8'h00;
        tick();

        // Reset during WAIT abandons the transaction
        ireq_valid = 1'b1; ireq_addr = 64'h8000_3004; mresp_ready = 1'b1;
        tick();
        check("rw_addr_ok", {63'd0, iresp_addr_ok}, 64'd1);
        tick();
        check("rw_in_wait", {62'd0, mreq_valid, iresp_data_ok}, 64'd0);
        reset = 1'b0;
        #1;
        check("rw_async_addr", mreq_addr, 64'd0);
        check("rw_async_oks", {59'd0, mreq_valid, iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok}, 64'd0);
        ireq_valid = 1'b0;
        tick();
        reset = 1'b1;
        mresp_valid = 1'b1; mresp_data = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("rw_ignored", {61'd0, mreq_valid, iresp_data_ok, dresp_data_ok}, 64'd0);
        end
        ireq_valid = 1'b1; mresp_data = 64'h7777_8888_9999_AAAA;
        sb.push_back('{1'b0, 64'h7777_8888});
        tick();
        check("rw_new_addr", mreq_addr, 64'h8000_3004);
        wait_resp("rw_new", 4, n);
        ireq_valid = 1'b0;
        tick();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive dbus grants while ibus waits.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous active-low reset (0 = reset asserted).
REQ-005 ireq_valid  in  1  fetch request; held until iresp_data_ok.
REQ-006 ireq_addr  in  64  fetch byte address.
REQ-007 iresp_addr_ok  out  1  ibus request accepted downstream.
REQ-008 iresp_data_ok  out  1  ibus data valid, one-cycle pulse.
REQ-009 iresp_data  out  32  instruction word.
REQ-010 dreq_valid  in  1  memory-stage request; held until dresp_data_ok.
REQ-011 dreq_addr  in  64  data byte address.
REQ-012 dreq_size  in  3  access size code, passed through.
REQ-013 dreq_strobe  in  8  byte write enables; all zero = load.
REQ-014 dreq_data  in  64  store data.
REQ-015 dresp_addr_ok  out  1  dbus request accepted downstream.
REQ-016 dresp_data_ok  out  1  dbus data valid, one-cycle pulse.
REQ-017 dresp_data  out  64  load data.
REQ-018 mreq_valid  out  1  downstream request.
REQ-019 mreq_is_write  out  1  1 = store.
REQ-020 mreq_addr / mreq_size / mreq_strobe / mreq_data  out  64/3/8/64  latched request fields.
REQ-021 mresp_ready  in  1  downstream accepts request this cycle.
REQ-022 mresp_valid  in  1  downstream response data valid.
REQ-023 mresp_data  in  64  downstream response data.

Function
REQ-024 FSM states SHALL be IDLE, REQ, WAIT, RESP; one outstanding transaction at a time.
REQ-025 IDLE: if any request valid, grant, latch owner and request fields, go REQ; else stay.
REQ-026 Priority: dbus wins when both valid, unless starve counter == STARVE_LIMIT, then ibus wins.
REQ-027 Starve counter: +1 on each dbus grant with ireq_valid high (saturating at STARVE_LIMIT); cleared on ibus grant or when ireq_valid low at a grant.
REQ-028 REQ: mreq_valid=1 with latched fields; on mresp_ready pulse owner addr_ok one cycle, go WAIT.
REQ-029 mresp_ready and mresp_valid in the same REQ cycle: go directly to RESP, latching data.
REQ-030 WAIT: on mresp_valid latch mresp_data, go RESP.
REQ-031 RESP: owner data_ok=1 for exactly this cycle with latched data; next state IDLE.
REQ-032 Minimum latency: grant cycle + REQ + RESP = data_ok 3 cycles after valid seen in IDLE with mresp_ready/mresp_valid tied high.
REQ-033 ibus fields: mreq_is_write=0, mreq_size=3'b010, mreq_strobe=0, mreq_data=0.
REQ-034 iresp_data = latched data[63:32] if latched ireq_addr[2]=1, else [31:0].
REQ-035 mreq_is_write = |dreq_strobe at grant.
REQ-036 Non-owner addr_ok/data_ok SHALL stay 0; requests arriving in non-IDLE states wait.
REQ-037 Request fields are latched at grant; upstream changes after grant SHALL NOT alter mreq_*.
REQ-038 mresp_valid outside REQ/WAIT SHALL be ignored.

Reset
REQ-039 reset=0 asynchronously forces IDLE, starve counter 0, owner none, all outputs 0.
REQ-040 reset mid-transaction: abandon it, no data_ok; mreq_valid drops immediately.
REQ-041 First grant possible in first rising edge after reset deasserts.

Verification
REQ-042 ireq_valid, addr 0x8000_0004, mresp_ready=mresp_valid=1, mresp_data=0x1111_2222_3333_4444 -> iresp_data_ok 3 cycles later, iresp_data=0x1111_2222.
REQ-043 Both valid at IDLE, dreq_strobe=0xFF, addr 0x8000_1000 -> dbus granted first, mreq_is_write=1; ibus granted after dresp_data_ok.
REQ-044 dreq_valid held continuously 5 times with ireq_valid high, STARVE_LIMIT=4 -> 5th grant goes to ibus.
REQ-045 mresp_ready delayed 3 cycles, mresp_valid 2 cycles later -> addr_ok on ready cycle, data_ok cycle after mresp_valid, mreq fields stable throughout.
REQ-046 reset=0 during WAIT -> outputs 0 that cycle, no data_ok; later mresp_valid ignored; new request served normally.
